// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC
// select codes and the priority decode that maps control inputs onto them.
package pc_seq_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4,
        SEL_TAIL = 3'd5
    } sel_t;

    // Next-PC priority: tail call, return, call, jump, branch, sequential.
    function automatic sel_t next_sel(input logic call, input logic ret,
                                      input logic jmp, input logic br_taken);
        sel_t s;
        if (call && ret)   s = SEL_TAIL;
        else if (ret)      s = SEL_RET;
        else if (call)     s = SEL_CALL;
        else if (jmp)      s = SEL_JMP;
        else if (br_taken) s = SEL_BR;
        else               s = SEL_SEQ;
        return s;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> PC sequencer bundle. The control unit (master) drives the
// redirect/stall controls; the sequencer (slave) returns PC and stack status.
interface pc_sequencer_if #(parameter int N = 32);
    logic         stall;
    logic         halt;
    logic         resume;
    logic         br_taken;
    logic [N-1:0] br_off;
    logic         jmp;
    logic         call;
    logic         ret;
    logic [N-1:0] jmp_tgt;
    logic [N-1:0] pc;
    logic [N-1:0] pc_seq;
    logic         halted;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_err;

    modport master (
        output stall, halt, resume, br_taken, br_off, jmp, call, ret, jmp_tgt,
        input  pc, pc_seq, halted, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, halt, resume, br_taken, br_off, jmp, call, ret, jmp_tgt,
        output pc, pc_seq, halted, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry (the write pointer has wrapped onto it) and keeps the count saturated.
// A replace on an empty stack acts as a push so a tail call with nothing to
// replace still records its return address. ovf/unf flag the offending
// operation in the same cycle it is requested.
module pc_ras #(
    parameter int N         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         replace,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [RAS_DEPTH-1:0][N-1:0] mem;
    logic [PW-1:0]               sp;      // next write slot
    logic [PW:0]                 cnt;
    logic [PW-1:0]               top_idx;
    logic                        do_push;
    logic                        do_repl;
    logic                        do_pop;

    assign top_idx = sp - 1'b1;
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(RAS_DEPTH));

    assign do_push = push | (replace & empty);
    assign do_repl = replace & ~empty;
    assign do_pop  = pop & ~empty;

    assign ovf = push & full;
    assign unf = pop & empty;

    // Pointer and occupancy; count saturates at RAS_DEPTH on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (do_push) begin
            sp <= sp + 1'b1;
            if (!full) cnt <= cnt + 1'b1;
        end else if (do_pop) begin
            sp  <= sp - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    // Entry storage; contents are meaningless after reset so no reset here.
    always_ff @(posedge clk) begin
        if (do_push)      mem[sp]      <= wdata;
        else if (do_repl) mem[top_idx] <= wdata;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, next-PC select (seq/branch/jump/call/
// ret/tail call), return-address stack and a RUN/HALT FSM. A control input
// is sampled on an edge and the resulting PC is visible one clock later.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int           N         = 32,
    parameter int           STEP      = 4,
    parameter logic [N-1:0] RESET_VEC = '0,
    parameter int           RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    state_t       state;
    logic         halted_r;
    logic         err_r;
    logic [N-1:0] pc_r;
    logic [N-1:0] pc_inc;
    logic [N-1:0] pc_next;
    logic [N-1:0] ras_top;
    logic         ras_empty;
    logic         ras_full;
    logic         ras_ovf;
    logic         ras_unf;
    logic         active;
    sel_t         sel;

    assign pc_inc = pc_r + N'(STEP);

    // Control is honoured only in RUN with no stall and no halt request.
    assign active = (state == S_RUN) && !bus.halt && !bus.stall;
    assign sel    = next_sel(bus.call, bus.ret, bus.jmp, bus.br_taken);

    // Next-PC mux; a return from an empty stack falls through sequentially.
    always_comb begin
        pc_next = pc_inc;
        case (sel)
            SEL_BR:                     pc_next = pc_r + bus.br_off;
            SEL_JMP, SEL_CALL, SEL_TAIL: pc_next = bus.jmp_tgt;
            SEL_RET:                    pc_next = ras_empty ? pc_inc : ras_top;
            default:                    pc_next = pc_inc;
        endcase
    end

    pc_ras #(
        .N         (N),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (active && sel == SEL_CALL),
        .pop     (active && sel == SEL_RET),
        .replace (active && sel == SEL_TAIL),
        .wdata   (pc_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );

    // RUN/HALT FSM with registered halted flag; halt outranks resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            halted_r <= 1'b0;
        end else begin
            case (state)
                S_RUN: if (bus.halt) begin
                    state    <= S_HALT;
                    halted_r <= 1'b1;
                end
                S_HALT: if (!bus.halt && bus.resume) begin
                    state    <= S_RUN;
                    halted_r <= 1'b0;
                end
                default: begin
                    state    <= S_RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // PC register advances only when control is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         pc_r <= RESET_VEC;
        else if (active) pc_r <= pc_next;
    end

    // Sticky stack error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err_r <= 1'b0;
        else if (ras_ovf || ras_unf)  err_r <= 1'b1;
    end

    assign bus.pc        = pc_r;
    assign bus.pc_seq    = pc_inc;
    assign bus.halted    = halted_r;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = err_r;

endmodule
